// File: rtl/regfile_bank.sv
// ---------------------------------------------------------------------------
// regfile_bank
//   Storage stage of the 32 x 64-bit architectural register file (X0..X31).
//   Each register is an enabled D flip-flop bank selected by a hierarchical
//   5-to-32 write decoder. The complete register array is presented on
//   'regs' so the downstream 32-to-1 read muxes can pick any register; this
//   block has no read address of its own.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears all storage
//   RegWrite       write enable for this cycle
//   WriteRegister  destination register index (5 bits)
//   WriteData      data to write (WIDTH bits)
//   regs           current contents, element i = Xi (X31 reads as zero)
//   written        bit i set once Xi has been written since reset
//   zero_wr        registered: previous edge sampled a write to ZERO_REG
// ---------------------------------------------------------------------------
module regfile_bank #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] regs [0:NREGS-1],
  output logic [NREGS-1:0] written,
  output logic             zero_wr
);

  // -------------------------------------------------------------------------
  // Write decoder: a 2-to-4 stage on the upper address bits produces group
  // enables, each of which gates a 3-to-8 stage on the lower bits. RegWrite
  // is folded into the first stage, so with RegWrite=0 every enable is 0
  // regardless of what WriteRegister carries (including X/Z).
  // -------------------------------------------------------------------------
  logic [3:0]       grp_en;
  logic [NREGS-1:0] wr_en;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec_2to4
      assign grp_en[gi] = RegWrite & (WriteRegister[4:3] == 2'(gi));
    end

    for (gi = 0; gi < NREGS; gi++) begin : g_dec_3to8
      assign wr_en[gi] = grp_en[gi / 8] & (WriteRegister[2:0] == 3'(gi % 8));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Register storage. ZERO_REG gets no flops at all: it is tied to zero and
  // never reports as written, so writes to it simply vanish.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        assign regs[gi]    = '0;
        assign written[gi] = 1'b0;
      end else begin : g_store
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;
        logic             wr_q;
        logic             wr_d;

        always_comb begin
          data_d = data_q;
          wr_d   = wr_q;
          if (wr_en[gi]) begin
            data_d = WriteData;
            wr_d   = 1'b1;
          end
        end

        // Reset has priority: a write on the same edge is lost.
        always_ff @(posedge clk) begin
          if (reset) begin
            data_q <= '0;
            wr_q   <= 1'b0;
          end else begin
            data_q <= data_d;
            wr_q   <= wr_d;
          end
        end

        assign regs[gi]    = data_q;
        assign written[gi] = wr_q;
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Attempted-write-to-XZR flag. The decoder still produces an enable for
  // ZERO_REG; it only feeds this flag.
  // -------------------------------------------------------------------------
  logic zero_wr_q;
  logic zero_wr_d;

  always_comb begin
    zero_wr_d = wr_en[ZERO_REG];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_wr_q <= 1'b0;
    end else begin
      zero_wr_q <= zero_wr_d;
    end
  end

  assign zero_wr = zero_wr_q;

endmodule

// File: tb/tb_regfile_bank.sv
// ---------------------------------------------------------------------------
// tb_regfile_bank
//   Self-checking bench for regfile_bank: a directed table of vectors, a few
//   hand-written multi-cycle sequences, and randomized traffic compared
//   against an array-based reference model of the register file.
// ---------------------------------------------------------------------------
module tb_regfile_bank;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [63:0] regs [0:31];
  logic [31:0] written;
  logic        zero_wr;

  regfile_bank #(
    .WIDTH   (64),
    .NREGS   (32),
    .ZERO_REG(31)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .regs         (regs),
    .written      (written),
    .zero_wr      (zero_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  // Reference model: plain array of register values plus flags.
  logic [63:0] m_regs [0:31];
  logic [31:0] m_written;
  logic        m_zero;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    int bad;
    bad = -1;
    for (int i = 31; i >= 0; i--) begin
      if (regs[i] !== m_regs[i]) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s regs[%0d] actual=%h required=%h", tag, bad, regs[bad], m_regs[bad]);
    end
    chk({tag, " written"}, {32'd0, written}, {32'd0, m_written});
    chk({tag, " zero_wr"}, {63'd0, zero_wr}, {63'd0, m_zero});
  endtask

  // Drive one transaction, advance one edge, update the model, compare.
  task automatic cycle(input logic rst, input logic we, input logic [4:0] addr,
                       input logic [63:0] data, input string tag);
    reset         = rst;
    RegWrite      = we;
    WriteRegister = addr;
    WriteData     = data;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_written = 32'd0;
      m_zero    = 1'b0;
    end else if (!we) begin
      m_zero = 1'b0;
    end else begin
      m_zero = (addr == 5'd31);
      if (addr != 5'd31) begin
        m_regs[addr]    = data;
        m_written[addr] = 1'b1;
      end
    end
    #1;
    txn++;
    $display("txn %0d %s rst=%b we=%b addr=%0d data=%h zero_wr=%b", txn, tag, rst, we, addr, data, zero_wr);
    compare_model(tag);
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
    int          idx;
    logic [63:0] exp_val;
    logic        exp_w;
    logic        exp_z;
  } vec_t;

  vec_t tbl [13];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] pat;

    tbl[0]  = '{1'b1, 1'b1, 5'd5,  64'hDEAD, 5,  64'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 5'd5,  64'hDEAD, 5,  64'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 5'd7,  64'h1234, 7,  64'h1234, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 5'd31, 64'hAAAA, 31, 64'h0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 31, 64'h0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 3,  64'h0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 5'd2,  64'h55, 2, 64'h55, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 5'd2,  64'h77, 2, 64'h0,  1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 5'd2,  64'h77, 2, 64'h77, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 5'd2,  64'h88, 2, 64'h88, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 5'd2,  64'h99, 2, 64'h99, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 5'd31, 64'hAAAA, 31, 64'h0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 5'bxxxxx, 64'h1111, 7, 64'h0, 1'b0, 1'b0};

    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_written = 32'd0;
    m_zero    = 1'b0;
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 64'd0;

    // Directed table.
    for (int v = 0; v < 13; v++) begin
      cycle(tbl[v].rst, tbl[v].we, tbl[v].addr, tbl[v].data, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d regs[%0d]", v, tbl[v].idx), regs[tbl[v].idx], tbl[v].exp_val);
      chk($sformatf("vec%0d written[%0d]", v, tbl[v].idx), {63'd0, written[tbl[v].idx]}, {63'd0, tbl[v].exp_w});
      chk($sformatf("vec%0d zero_wr", v), {63'd0, zero_wr}, {63'd0, tbl[v].exp_z});
    end

    // Sweep: write every writable register, then read all through a mux view.
    cycle(1'b1, 1'b0, 5'd0, 64'd0, "sweep_rst");
    for (int i = 0; i < 31; i++) begin
      cycle(1'b0, 1'b1, 5'(i), 64'(i) * 64'h0101_0101_0101_0101, "sweep_wr");
    end
    for (int sel = 0; sel < 32; sel++) begin
      pat = (sel == 31) ? 64'd0 : 64'(sel) * 64'h0101_0101_0101_0101;
      chk($sformatf("sweep mux sel=%0d", sel), regs[sel], pat);
    end
    chk("sweep written", {32'd0, written}, 64'h0000_0000_7FFF_FFFF);

    // Latency: before the sampling edge the old value is still visible.
    reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h1234;
    #2;
    chk("latency pre-edge regs[7]", regs[7], 64'h0707_0707_0707_0707);
    cycle(1'b0, 1'b1, 5'd7, 64'h1234, "latency_wr");
    chk("latency post-edge regs[7]", regs[7], 64'h1234);
    cycle(1'b0, 1'b0, 5'd7, 64'h0, "latency_hold");
    chk("latency hold regs[7]", regs[7], 64'h1234);

    // RegWrite=0 for five cycles: nothing may change.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, "nowrite");
    end
    chk("nowrite regs[3]", regs[3], 64'h0303_0303_0303_0303);

    // Zero-register pulse lasts exactly one cycle.
    cycle(1'b0, 1'b1, 5'd31, 64'hAAAA, "zr_wr");
    chk("zr pulse", {63'd0, zero_wr}, 64'd1);
    chk("zr regs[31]", regs[31], 64'd0);
    cycle(1'b0, 1'b1, 5'd4, 64'h44, "zr_after");
    chk("zr pulse end", {63'd0, zero_wr}, 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), {$urandom, $urandom}, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
